v_ex_stage: RTL

//  Vector execute stage directly downstream of vector decode. Accepts one decoded op per handshake
//  (ALU opcode, two VREG_DW operands, memory request, write-back tags). VADD/NOP complete in 1 cycle;

---
 rtl/v_ex_stage_pkg.sv | 33 +++
 rtl/v_lane_mul.sv | 10 +
 rtl/v_ex_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/v_ex_stage_pkg.sv
// rtl/v_ex_stage_pkg.sv - shared widths, ALU opcodes and FSM states for the vector execute stage
package v_ex_stage_pkg;
  localparam int VLMAX     = 8;
  localparam int SEW       = 32;
  localparam int VALUOP_DW = 5;
  localparam int VREG_DW   = VLMAX * SEW;
  localparam int VREG_AW   = 5;
  localparam int VMEM_DW   = 256;
  localparam int VMEM_AW   = 32;
  localparam int CNT_W     = $clog2(VLMAX);

  localparam logic [VALUOP_DW-1:0] VALU_OP_NOP  = 5'd0;
  localparam logic [VALUOP_DW-1:0] VALU_OP_VADD = 5'd1;
  localparam logic [VALUOP_DW-1:0] VALU_OP_VMUL = 5'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } vex_state_e;

  typedef logic [VLMAX-1:0][SEW-1:0] vlanes_t;

  // Memory request and write-back tags that travel with each op.
  typedef struct packed {
    logic               ren;
    logic               wen;
    logic [VMEM_AW-1:0] addr;
    logic [VMEM_DW-1:0] din;
    logic               wb_en;
    logic               wb_sel;
    logic [VREG_AW-1:0] wb_addr;
  } vex_side_t;
endpackage

// File: rtl/v_lane_mul.sv
// rtl/v_lane_mul.sv - single SEW x SEW lane multiplier, low SEW bits of the product
module v_lane_mul
  import v_ex_stage_pkg::*;
(
  input  logic [SEW-1:0] a_i,
  input  logic [SEW-1:0] b_i,
  output logic [SEW-1:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

// File: rtl/v_ex_stage.sv
// rtl/v_ex_stage.sv - vector execute stage: 1-cycle VADD/NOP, lane-serial VMUL, registered result bundle
module v_ex_stage
  import v_ex_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [VALUOP_DW-1:0] valu_opcode_i,
  input  logic [VREG_DW-1:0]   operand_v1_i,
  input  logic [VREG_DW-1:0]   operand_v2_i,
  input  logic                 vmem_ren_i,
  input  logic                 vmem_wen_i,
  input  logic [VMEM_AW-1:0]   vmem_addr_i,
  input  logic [VMEM_DW-1:0]   vmem_din_i,
  input  logic                 vid_wb_en_i,
  input  logic                 vid_wb_sel_i,
  input  logic [VREG_AW-1:0]   vid_wb_addr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [VREG_DW-1:0]   valu_result_o,
  output logic                 vmem_ren_o,
  output logic                 vmem_wen_o,
  output logic [VMEM_AW-1:0]   vmem_addr_o,
  output logic [VMEM_DW-1:0]   vmem_din_o,
  output logic                 vex_wb_en_o,
  output logic                 vex_wb_sel_o,
  output logic [VREG_AW-1:0]   vex_wb_addr_o,
  output logic                 busy_o
);
  vex_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  vlanes_t   v1_q, v1_d, v2_q, v2_d, acc_q, acc_d;
  vex_side_t side_q, side_d;

  logic      out_valid_q, out_valid_d;
  vlanes_t   result_q, result_d;
  vex_side_t oside_q, oside_d;

  vex_side_t side_in;
  vlanes_t   op1, op2, vadd_res;
  logic [SEW-1:0] mul_p;
  logic      accept, load_out;

  assign op1 = operand_v1_i;
  assign op2 = operand_v2_i;
  assign side_in = '{ren: vmem_ren_i, wen: vmem_wen_i, addr: vmem_addr_i, din: vmem_din_i,
                     wb_en: vid_wb_en_i, wb_sel: vid_wb_sel_i, wb_addr: vid_wb_addr_i};

  assign in_ready_o = (state_q == ST_IDLE) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    vadd_res = '0;
    for (int l = 0; l < VLMAX; l++) begin
      vadd_res[l] = op1[l] + op2[l];
    end
  end

  v_lane_mul u_lane_mul (
    .a_i (v1_q[cnt_q]),
    .b_i (v2_q[cnt_q]),
    .p_o (mul_p)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    acc_d    = acc_q;
    side_d   = side_q;
    load_out = 1'b0;
    result_d = result_q;
    oside_d  = oside_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (valu_opcode_i == VALU_OP_VMUL) begin
            state_d = ST_MUL;
            cnt_d   = '0;
            v1_d    = op1;
            v2_d    = op2;
            side_d  = side_in;
          end else begin
            load_out = 1'b1;
            result_d = (valu_opcode_i == VALU_OP_VADD) ? vadd_res : '0;
            oside_d  = side_in;
          end
        end
      end
      ST_MUL: begin
        acc_d[cnt_q] = mul_p;
        cnt_d        = cnt_q + 1'b1;
        // The output slot was drained when this op was accepted, so the load cannot collide.
        if (cnt_q == CNT_W'(VLMAX - 1)) begin
          load_out = 1'b1;
          result_d = acc_d;
          oside_d  = side_q;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_out) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      acc_q       <= '0;
      side_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      oside_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      acc_q       <= acc_d;
      side_q      <= side_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      oside_q     <= oside_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign valu_result_o = result_q;
  assign vmem_ren_o    = oside_q.ren;
  assign vmem_wen_o    = oside_q.wen;
  assign vmem_addr_o   = oside_q.addr;
  assign vmem_din_o    = oside_q.din;
  assign vex_wb_en_o   = oside_q.wb_en;
  assign vex_wb_sel_o  = oside_q.wb_sel;
  assign vex_wb_addr_o = oside_q.wb_addr;
  assign busy_o        = (state_q != ST_IDLE);
endmodule
